player_ctrl: RTL

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/game_pkg.sv | 23 ++
 rtl/key_debounce.sv | 50 +++++
 rtl/player_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: screen/ship geometry defaults, shot state encoding
// and the alien block layout constants used by the downstream alien logic.
package game_pkg;

    localparam int COORD_W      = 10;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int SHIP_W_DEF   = 32;
    localparam int SHIP_Y_DEF   = 440;

    localparam int ALIEN_ROWS   = 4;
    localparam int ALIEN_COLS   = 8;
    localparam int ALIEN_W      = 24;
    localparam int ALIEN_H      = 16;
    localparam int ALIEN_GAP    = 8;

    typedef enum logic {
        SHOT_IDLE = 1'b0,
        SHOT_FLY  = 1'b1
    } shot_state_e;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, consecutive-cycle debounce, and a
// one-cycle pulse when the accepted level falls (button pressed).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iKEY_N,
    output logic oLEVEL,
    output logic oPRESS
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= iKEY_N;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                // The last mismatching cycle flips the level; a press is a 1->0 flip
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_press <= r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign oLEVEL = r_level;
    assign oPRESS = r_press;

endmodule

// File: rtl/player_ctrl.sv
// Player ship movement and single-shot launcher driven by debounced keys,
// advancing once per frame tick.
module player_ctrl
    import game_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SHIP_W       = SHIP_W_DEF,
    parameter int SHIP_Y       = SHIP_Y_DEF,
    parameter int SHIP_STEP    = 4,
    parameter int SHOT_STEP    = 8,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iKEY_LEFT_N,
    input  logic               iKEY_RIGHT_N,
    input  logic               iKEY_FIRE_N,
    input  logic               iFRAME_TICK,
    input  logic               iHIT,
    output logic [COORD_W-1:0] oSHIP_X,
    output logic [COORD_W-1:0] oSHOT_X,
    output logic [COORD_W-1:0] oSHOT_Y,
    output logic               oSHOT_ACTIVE,
    output logic               oFIRE_PULSE
);
    localparam int X_MAX = SCREEN_W - SHIP_W;

    logic w_left_lvl, w_left_press;
    logic w_right_lvl, w_right_press;
    logic w_fire_lvl, w_fire_press;
    logic w_unused_ok;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_left (
        .iCLK(iCLK), .iRST(iRST), .iKEY_N(iKEY_LEFT_N),
        .oLEVEL(w_left_lvl), .oPRESS(w_left_press)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_right (
        .iCLK(iCLK), .iRST(iRST), .iKEY_N(iKEY_RIGHT_N),
        .oLEVEL(w_right_lvl), .oPRESS(w_right_press)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_fire (
        .iCLK(iCLK), .iRST(iRST), .iKEY_N(iKEY_FIRE_N),
        .oLEVEL(w_fire_lvl), .oPRESS(w_fire_press)
    );

    assign w_unused_ok = &{1'b0, w_left_press, w_right_press, w_fire_lvl};

    // Saturating one-frame ship move; opposing keys cancel
    function automatic logic [COORD_W-1:0] f_ship_step(
        input logic [COORD_W-1:0] x,
        input logic               left,
        input logic               right
    );
        logic [COORD_W:0] w_sum;
        w_sum = {1'b0, x} + (COORD_W + 1)'(SHIP_STEP);
        if (left && !right)
            return (x < COORD_W'(SHIP_STEP)) ? '0 : x - COORD_W'(SHIP_STEP);
        if (right && !left)
            return (w_sum > (COORD_W + 1)'(X_MAX)) ? COORD_W'(X_MAX) : w_sum[COORD_W-1:0];
        return x;
    endfunction

    logic [COORD_W-1:0] r_ship_x;
    logic [COORD_W-1:0] r_shot_x;
    logic [COORD_W-1:0] r_shot_y;
    logic               r_pend;
    logic               r_fire_pulse;
    shot_state_e        r_state;

    always_ff @(posedge iCLK) begin
        if (iRST)
            r_ship_x <= COORD_W'(X_MAX / 2);
        else if (iFRAME_TICK)
            r_ship_x <= f_ship_step(r_ship_x, ~w_left_lvl, ~w_right_lvl);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state      <= SHOT_IDLE;
            r_shot_x     <= '0;
            r_shot_y     <= '0;
            r_pend       <= 1'b0;
            r_fire_pulse <= 1'b0;
        end else begin
            r_fire_pulse <= 1'b0;
            case (r_state)
                SHOT_IDLE: begin
                    // Launch from the ship position as it was before this tick's move
                    if (iFRAME_TICK && r_pend) begin
                        r_state      <= SHOT_FLY;
                        r_shot_x     <= r_ship_x + COORD_W'(SHIP_W / 2 - 1);
                        r_shot_y     <= COORD_W'(SHIP_Y - 8);
                        r_pend       <= 1'b0;
                        r_fire_pulse <= 1'b1;
                    end else if (w_fire_press) begin
                        r_pend <= 1'b1;
                    end
                end
                SHOT_FLY: begin
                    if (iHIT)
                        r_state <= SHOT_IDLE;
                    else if (iFRAME_TICK) begin
                        if (r_shot_y < COORD_W'(SHOT_STEP))
                            r_state <= SHOT_IDLE;
                        else
                            r_shot_y <= r_shot_y - COORD_W'(SHOT_STEP);
                    end
                end
                default: r_state <= SHOT_IDLE;
            endcase
        end
    end

    assign oSHIP_X      = r_ship_x;
    assign oSHOT_X      = r_shot_x;
    assign oSHOT_Y      = r_shot_y;
    assign oSHOT_ACTIVE = (r_state == SHOT_FLY);
    assign oFIRE_PULSE  = r_fire_pulse;

endmodule
